slot_allocator: RTL and testbench
=================================

Name: slot_allocator

Overview:
- Free-slot allocator for a fixed pool of ENTRIES entries (ROB/LSQ/issue-queue style).
- Holds a registered occupancy bitmap and grants the lowest-index free slot each cycle.
- Free-slot search uses one priencoder instance with SEARCH_BIT=0 over the bitmap; its invalid output is the full indication.
- Sits upstream of the structure that owns the slots. Consumers return slots through the free port, and a pipeline flush releases every slot at once.

Parameters:
- ENTRIES, 32, number of slots; power of two, >= 2.
- IDXW, $clog2(ENTRIES), slot index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  requester wants one slot this cycle.
- alloc_ack  out  1  grant: slot alloc_idx is taken at this edge.
- alloc_idx  out  IDXW  lowest-index free slot; valid when alloc_ack=1.
- free_valid  in  1  release the slot named by free_idx.
- free_idx  in  IDXW  slot being released.
- flush  in  1  release all slots.
- used_vec  out  ENTRIES  registered occupancy bitmap; bit i=1 means slot i is in use.
- count  out  IDXW+1  registered number of used slots, 0..ENTRIES.
- full  out  1  count==ENTRIES (registered).
- empty  out  1  count==0 (registered).
- err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): used_vec=0, count=0, empty=1, full=0, err=0. rst overrides every other input in that cycle.
- Grant path, combinational from registered used_vec (zero-cycle latency):
  - alloc_idx = index of the lowest 0 bit of used_vec; 0 when full.
  - alloc_ack = alloc_req & ~full & ~flush.
  - No ack without req.
- Handshake: a request is either granted in the same cycle or dropped. No queuing. The requester re-asserts alloc_req on a later cycle.
- Next-state when flush=0:
  - used_vec' = (used_vec | (alloc_ack ? onehot(alloc_idx) : 0)) & ~(legal_free ? onehot(free_idx) : 0).
  - legal_free = free_valid & used_vec[free_idx].
  - count' = count + alloc_ack - legal_free.
  - full' and empty' are computed from count'.
- Simultaneous alloc + free:
  - Both take effect at the same edge and count is unchanged.
  - The freed slot is not eligible for grant until the next cycle, because the grant uses the current bitmap.
  - Allocating from full with a same-cycle free is refused (ack=0).
- Free of an unused slot (free_valid & ~used_vec[free_idx]): ignored. Bitmap and count are unchanged.
- Flush: at the edge, used_vec=0 and count=0. alloc_ack is 0 during the flush cycle. free_valid is ignored. err is unchanged.
- Invariant: count == popcount(used_vec) at all times.
- No wrap-around state. Allocation order is purely lowest-free-index, not FIFO.

Optional Feature:
- Macro: SLOT_ALLOC_CHECK_EN.
- Defined:
  - err is set at the edge after an illegal free (free_valid=1, flush=0, used_vec[free_idx]=0).
  - err is set at the edge after any free_valid with free_idx >= ENTRIES (reachable only if ENTRIES is not a power of two; treated as illegal).
  - err stays set until rst; flush does not clear it.
  - Simulation-only $display of the offending index.
- Undefined:
  - err is tied to 0.
  - Illegal frees are still silently ignored as in Behaviour.
  - No added logic.

Test Plan:
- Reset, then alloc_req=1 for 3 cycles (ENTRIES=32) -> alloc_idx=0,1,2 with ack=1 each cycle; afterwards used_vec=0x7, count=3.
- Starting from used_vec=0x7: free_idx=1, then alloc_req=1 on the next cycle -> alloc_idx=1; count goes 2 then 3.
- Fill to 32 slots: full=1 and alloc_req=1 -> ack=0, alloc_idx=0. In the same cycle free_idx=5 -> next cycle full=0, count=31, alloc_idx=5.
- Simultaneous alloc_req=1 and free_idx=0 with used_vec=0x3 -> ack=1, alloc_idx=2; next used_vec=0x6, count=2.
- flush=1 with count=17 and alloc_req=1 -> ack=0; next cycle used_vec=0, count=0, empty=1. Also assert rst mid-fill -> all outputs return to reset values.
- With SLOT_ALLOC_CHECK_EN defined, free_idx=9 while used_vec[9]=0 -> state unchanged, err=1 next cycle and still 1 after a flush. Without the macro, err stays 0.

Source files
------------

// File: rtl/slot_allocator.sv
// Free-slot allocator: registered occupancy bitmap with a lowest-free-index grant.
// Optional protocol checking (sticky err on illegal frees) is enabled by defining SLOT_ALLOC_CHECK_EN.

module priencoder #(
    parameter  int WIDTH      = 32,
    parameter  bit SEARCH_BIT = 1'b0,
    localparam int IW         = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i] == SEARCH_BIT) begin
                idx   = i[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

module slot_allocator #(
    parameter  int ENTRIES = 32,
    localparam int IDXW    = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    output logic               alloc_ack,
    output logic [IDXW-1:0]    alloc_idx,
    input  logic               free_valid,
    input  logic [IDXW-1:0]    free_idx,
    input  logic               flush,
    output logic [ENTRIES-1:0] used_vec,
    output logic [IDXW:0]      count,
    output logic               full,
    output logic               empty,
    output logic               err
);

    logic [ENTRIES-1:0] used_vec_q, used_vec_d;
    logic [IDXW:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    logic [IDXW-1:0]    search_idx;
    logic               search_valid;
    logic               free_in_range;
    logic               legal_free;
    logic [ENTRIES-1:0] set_mask;
    logic [ENTRIES-1:0] clr_mask;

    priencoder #(
        .WIDTH      (ENTRIES),
        .SEARCH_BIT (1'b0)
    ) u_free_search (
        .vec   (used_vec_q),
        .idx   (search_idx),
        .valid (search_valid)
    );

    // No free bit found means the pool is full; the grant is refused during a flush.
    assign alloc_idx = search_idx;
    assign alloc_ack = alloc_req & search_valid & ~flush;

    assign free_in_range = ({1'b0, free_idx} < (IDXW+1)'(ENTRIES));
    assign legal_free    = free_valid & free_in_range & used_vec_q[free_idx];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_ack) begin
            set_mask[alloc_idx] = 1'b1;
        end
        if (legal_free) begin
            clr_mask[free_idx] = 1'b1;
        end
    end

    always_comb begin
        used_vec_d = used_vec_q;
        count_d    = count_q;
        if (flush) begin
            used_vec_d = '0;
            count_d    = '0;
        end else begin
            used_vec_d = (used_vec_q | set_mask) & ~clr_mask;
            count_d    = count_q + (IDXW+1)'(alloc_ack) - (IDXW+1)'(legal_free);
        end
        full_d  = (count_d == (IDXW+1)'(ENTRIES));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_vec_q <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            used_vec_q <= used_vec_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    assign used_vec = used_vec_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;

`ifdef SLOT_ALLOC_CHECK_EN
    logic err_q, err_d;
    logic bad_free;

    // Out-of-range indices are illegal even during a flush; unused-slot frees only outside one.
    always_comb begin
        bad_free = 1'b0;
        if (free_valid) begin
            if (!free_in_range) begin
                bad_free = 1'b1;
            end else if (!flush && !used_vec_q[free_idx]) begin
                bad_free = 1'b1;
            end
        end
        err_d = err_q | bad_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && bad_free) begin
            $display("slot_allocator: illegal free of slot %0d", free_idx);
        end
    end
`endif

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

`ifndef SYNTHESIS
    count_matches_bitmap: assert property (@(posedge clk) disable iff (rst)
        count_q == (IDXW+1)'($countones(used_vec_q)));
`endif

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator: directed vector table, hand-written
// boundary sequences, and randomized traffic against a behavioural pool model.

module tb_slot_allocator;

    localparam int ENTRIES = 32;
    localparam int IDXW    = 5;
`ifdef SLOT_ALLOC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               alloc_req;
    logic               alloc_ack;
    logic [IDXW-1:0]    alloc_idx;
    logic               free_valid;
    logic [IDXW-1:0]    free_idx;
    logic               flush;
    logic [ENTRIES-1:0] used_vec;
    logic [IDXW:0]      count;
    logic               full;
    logic               empty;
    logic               err;

    int n_checks = 0;
    int n_fail   = 0;

    slot_allocator #(.ENTRIES(ENTRIES)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_ack  (alloc_ack),
        .alloc_idx  (alloc_idx),
        .free_valid (free_valid),
        .free_idx   (free_idx),
        .flush      (flush),
        .used_vec   (used_vec),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs, check the grant before the edge, check state after it.
    task automatic step(input logic r, input logic req, input logic fv, input logic [IDXW-1:0] fi,
                        input logic fl, input logic e_ack, input logic [IDXW-1:0] e_idx,
                        input logic [ENTRIES-1:0] e_used, input logic [IDXW:0] e_cnt,
                        input logic e_err, input string nm);
        @(negedge clk);
        rst        = r;
        alloc_req  = req;
        free_valid = fv;
        free_idx   = fi;
        flush      = fl;
        #1;
        chk({nm, ".ack"}, 64'(alloc_ack), 64'(e_ack));
        chk({nm, ".idx"}, 64'(alloc_idx), 64'(e_idx));
        @(posedge clk);
        #1;
        chk({nm, ".used"},  64'(used_vec), 64'(e_used));
        chk({nm, ".count"}, 64'(count),    64'(e_cnt));
        chk({nm, ".full"},  64'(full),     64'(e_cnt == 6'd32));
        chk({nm, ".empty"}, 64'(empty),    64'(e_cnt == 6'd0));
        chk({nm, ".err"},   64'(err),      64'(e_err));
    endtask

    typedef struct {
        logic               r;
        logic               req;
        logic               fv;
        logic [IDXW-1:0]    fi;
        logic               fl;
        logic               e_ack;
        logic [IDXW-1:0]    e_idx;
        logic [ENTRIES-1:0] e_used;
        logic [IDXW:0]      e_cnt;
        logic               e_errc;   // expected err when checking is compiled in
    } vec_t;

    vec_t vecs[13];

    // Behavioural model: an array of occupancy flags.
    bit m_used[ENTRIES];
    bit m_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < ENTRIES; i++) c += int'(m_used[i]);
        return c;
    endfunction

    function automatic logic [ENTRIES-1:0] m_vec();
        logic [ENTRIES-1:0] v = '0;
        for (int i = 0; i < ENTRIES; i++) v[i] = m_used[i];
        return v;
    endfunction

    initial begin
        rst = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_idx = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.used",  64'(used_vec), 64'd0);
        chk("reset.count", 64'(count),    64'd0);
        chk("reset.full",  64'(full),     64'd0);
        chk("reset.empty", 64'(empty),    64'd1);
        chk("reset.err",   64'(err),      64'd0);

        //          r    req  fv   fi  fl   ack  idx  used        cnt errc
        vecs[0]  = '{1'b0,1'b1,1'b0,5'd0,1'b0,1'b1,5'd0,32'h1,      6'd1,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,5'd0,1'b0,1'b1,5'd1,32'h3,      6'd2,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,5'd0,1'b0,1'b1,5'd2,32'h7,      6'd3,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b1,5'd1,1'b0,1'b0,5'd3,32'h5,      6'd2,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,5'd0,1'b0,1'b1,5'd1,32'h7,      6'd3,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b1,5'd2,1'b0,1'b0,5'd3,32'h3,      6'd2,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b1,5'd0,1'b0,1'b1,5'd2,32'h6,      6'd2,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,5'd9,1'b0,1'b0,5'd0,32'h6,      6'd2,1'b1};
        vecs[8]  = '{1'b0,1'b1,1'b1,5'd1,1'b0,1'b1,5'd0,32'h5,      6'd2,1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b1,5'd0,1'b1,1'b0,5'd1,32'h0,      6'd0,1'b1};
        vecs[10] = '{1'b1,1'b1,1'b0,5'd0,1'b0,1'b1,5'd0,32'h0,      6'd0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,5'd0,1'b0,1'b1,5'd0,32'h1,      6'd1,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,5'd0,1'b0,1'b0,5'd1,32'h0,      6'd0,1'b0};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].r, vecs[i].req, vecs[i].fv, vecs[i].fi, vecs[i].fl,
                 vecs[i].e_ack, vecs[i].e_idx, vecs[i].e_used, vecs[i].e_cnt,
                 CHK & vecs[i].e_errc, $sformatf("vec%0d", i));
        end

        // Fill to full, refuse at full even with a same-cycle free, then reuse the freed slot.
        for (int i = 0; i < ENTRIES; i++) begin
            logic [32:0] m;
            m = (33'd1 << (i + 1)) - 33'd1;
            step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, IDXW'(i), m[31:0], 6'(i + 1), 1'b0,
                 $sformatf("fill%0d", i));
        end
        step(1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 6'd32, 1'b0, "full_req");
        step(1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFDF, 6'd31, 1'b0, "full_free5");
        step(1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 6'd32, 1'b0, "refill5");
        step(1'b1, 1'b0, 1'b0, '0,   1'b0, 1'b0, 5'd0, 32'h0,         6'd0,  1'b0, "rst_full");

        // Flush at count 17 with a request pending, then reset in the middle of a fill.
        for (int i = 0; i < 17; i++) begin
            logic [32:0] m;
            m = (33'd1 << (i + 1)) - 33'd1;
            step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, IDXW'(i), m[31:0], 6'(i + 1), 1'b0,
                 $sformatf("fill17_%0d", i));
        end
        step(1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd17, 32'h0, 6'd0, 1'b0, "flush17");
        for (int i = 0; i < 5; i++) begin
            logic [32:0] m;
            m = (33'd1 << (i + 1)) - 33'd1;
            step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, IDXW'(i), m[31:0], 6'(i + 1), 1'b0,
                 $sformatf("fill5_%0d", i));
        end
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 5'd5, 32'h0, 6'd0, 1'b0, "rst_midfill");

        // Illegal free: state untouched; err (when checked) survives a flush, cleared by rst.
        step(1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 32'h0, 6'd0, CHK, "bad_free9");
        step(1'b0, 1'b0, 1'b0, '0,   1'b1, 1'b0, 5'd0, 32'h0, 6'd0, CHK, "flush_keeps_err");
        step(1'b1, 1'b0, 1'b0, '0,   1'b0, 1'b0, 5'd0, 32'h0, 6'd0, 1'b0, "rst_clears_err");

        // Randomized traffic against the model.
        for (int i = 0; i < ENTRIES; i++) m_used[i] = 1'b0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, req, fv, fl, e_ack;
            logic [IDXW-1:0] fi, e_idx;
            int lowest;
            r   = ($urandom % 300) == 0;
            req = ($urandom % 4) != 0;
            fv  = ($urandom % 3) == 0;
            fi  = IDXW'($urandom % ENTRIES);
            fl  = ($urandom % 150) == 0;

            lowest = -1;
            for (int k = ENTRIES - 1; k >= 0; k--) if (!m_used[k]) lowest = k;
            e_idx = (lowest < 0) ? '0 : IDXW'(lowest);
            e_ack = req && (lowest >= 0) && !fl;

            if (r) begin
                for (int k = 0; k < ENTRIES; k++) m_used[k] = 1'b0;
                m_err = 1'b0;
            end else if (fl) begin
                for (int k = 0; k < ENTRIES; k++) m_used[k] = 1'b0;
            end else begin
                bit was_used;
                was_used = m_used[fi];
                if (e_ack) m_used[lowest] = 1'b1;
                if (fv && was_used) m_used[fi] = 1'b0;
                if (fv && !was_used && CHK) m_err = 1'b1;
            end

            step(r, req, fv, fi, fl, e_ack, e_idx, m_vec(), 6'(m_count()), m_err,
                 $sformatf("rand%0d", cyc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
